// File: rtl/pipeline_pkg.sv
// Shared definitions for the writeback stage: result-select encodings,
// the default link register and a lane-slicing helper.
package pipeline_pkg;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam int LINK_REG_DEFAULT = 31;

  // Lowest bit of lane `lane` in a bus packed as lanes of `width` bits.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/wb_lane.sv
// One writeback lane: M->W pipeline registers with stall/flush, followed by
// the result mux and the link-register override on the registered values.
module wb_lane
  import pipeline_pkg::*;
#(
  parameter int DW       = 32,
  parameter int RW       = 5,
  parameter int LINK_REG = LINK_REG_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallW,
  input  logic          flushW,
  input  logic          validM,
  input  logic          RegWriteM,
  input  logic          jumpM,
  input  logic [1:0]    MemtoRegM,
  input  logic [DW-1:0] ReadDataM,
  input  logic [DW-1:0] aluoutM,
  input  logic [DW-1:0] PCPlus8M,
  input  logic [RW-1:0] writeregM,
  output logic          valid,
  output logic          reg_write,
  output logic [RW-1:0] write_reg,
  output logic [DW-1:0] result
);

  logic          valid_r;
  logic          reg_write_r;
  logic          jump_r;
  logic [1:0]    sel_r;
  logic [DW-1:0] read_data_r;
  logic [DW-1:0] alu_r;
  logic [DW-1:0] pc_plus8_r;
  logic [RW-1:0] writereg_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      jump_r      <= 1'b0;
      sel_r       <= SEL_ALU;
      read_data_r <= '0;
      alu_r       <= '0;
      pc_plus8_r  <= '0;
      writereg_r  <= '0;
    end else if (flushW) begin
      // Only the control bits need clearing; a bubble's data is never used.
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
    end else if (!stallW) begin
      valid_r     <= validM;
      reg_write_r <= RegWriteM;
      jump_r      <= jumpM;
      sel_r       <= MemtoRegM;
      read_data_r <= ReadDataM;
      alu_r       <= aluoutM;
      pc_plus8_r  <= PCPlus8M;
      writereg_r  <= writeregM;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    result = alu_r;
    case (sel_r)
      SEL_MEM:  result = read_data_r;
      SEL_LINK: result = pc_plus8_r;
      SEL_ALU:  result = alu_r;
      default:  result = alu_r;
    endcase
  end

  assign valid     = valid_r;
  assign reg_write = reg_write_r;
  assign write_reg = jump_r ? RW'(LINK_REG) : writereg_r;

endmodule

// File: rtl/writeback_stage_n.sv
// N-lane writeback stage: per-lane registers and result select, same-bundle
// write-conflict resolution (youngest wins), $0 suppression and retire count.
module writeback_stage_n
  import pipeline_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int DW       = 32,
  parameter int RW       = 5,
  parameter int LINK_REG = LINK_REG_DEFAULT,
  parameter int CNT_W    = 32,
  localparam int RTW     = $clog2(LANES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallW,
  input  logic                flushW,
  input  logic [LANES-1:0]    validM,
  input  logic [LANES-1:0]    RegWriteM,
  input  logic [LANES-1:0]    jumpM,
  input  logic [2*LANES-1:0]  MemtoRegM,
  input  logic [DW*LANES-1:0] ReadDataM,
  input  logic [DW*LANES-1:0] aluoutM,
  input  logic [DW*LANES-1:0] PCPlus8M,
  input  logic [RW*LANES-1:0] writeregM,
  output logic [LANES-1:0]    RegWriteW,
  output logic [DW*LANES-1:0] ResultW,
  output logic [RW*LANES-1:0] WriteRegW,
  output logic [RTW-1:0]      retiredW,
  output logic [CNT_W-1:0]    retire_count
);

  logic [LANES-1:0] lane_valid;
  logic [LANES-1:0] lane_rw;
  logic [LANES-1:0] kill;
  logic [RW-1:0]    lane_wr [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    wb_lane #(
      .DW       (DW),
      .RW       (RW),
      .LINK_REG (LINK_REG)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .stallW    (stallW),
      .flushW    (flushW),
      .validM    (validM[i]),
      .RegWriteM (RegWriteM[i]),
      .jumpM     (jumpM[i]),
      .MemtoRegM (MemtoRegM[lane_lsb(i, 2) +: 2]),
      .ReadDataM (ReadDataM[lane_lsb(i, DW) +: DW]),
      .aluoutM   (aluoutM[lane_lsb(i, DW) +: DW]),
      .PCPlus8M  (PCPlus8M[lane_lsb(i, DW) +: DW]),
      .writeregM (writeregM[lane_lsb(i, RW) +: RW]),
      .valid     (lane_valid[i]),
      .reg_write (lane_rw[i]),
      .write_reg (lane_wr[i]),
      .result    (ResultW[lane_lsb(i, DW) +: DW])
    );

    assign WriteRegW[lane_lsb(i, RW) +: RW] = lane_wr[i];
    assign RegWriteW[i] = lane_valid[i] & lane_rw[i] & (lane_wr[i] != '0) & ~kill[i];
  end

  // A lane loses its write when any younger lane in the bundle targets the
  // same register, leaving one enable per register.
  always_comb begin
    kill = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (lane_valid[j] && lane_rw[j] && (lane_wr[j] == lane_wr[i])) kill[i] = 1'b1;
      end
    end
  end

  always_comb begin
    retiredW = '0;
    for (int i = 0; i < LANES; i++) retiredW = retiredW + RTW'(lane_valid[i]);
  end

  // The W bundle is counted on the edge where it leaves: a normal advance or
  // a flush, so a bundle held by a stall is counted exactly once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_count <= '0;
    end else if (!stallW || flushW) begin
      retire_count <= retire_count + CNT_W'(retiredW);
    end
  end

endmodule

// File: tb/tb_writeback_stage_n.sv
// Directed bench for writeback_stage_n: 2-lane, 4-lane and 4-bit-counter
// instances share one stimulus bus; expected values are written out by hand.
module tb_writeback_stage_n;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         flush;
  logic [3:0]   valid;
  logic [3:0]   regw;
  logic [3:0]   jump;
  logic [7:0]   sel;
  logic [127:0] rdata;
  logic [127:0] alu;
  logic [127:0] pc8;
  logic [19:0]  wreg;

  logic [1:0]  d2_rw;
  logic [63:0] d2_res;
  logic [9:0]  d2_wr;
  logic [1:0]  d2_ret;
  logic [31:0] d2_cnt;

  logic [3:0]   d4_rw;
  logic [127:0] d4_res;
  logic [19:0]  d4_wr;
  logic [2:0]   d4_ret;
  logic [31:0]  d4_cnt;

  logic [1:0]  dw_rw;
  logic [63:0] dw_res;
  logic [9:0]  dw_wr;
  logic [1:0]  dw_ret;
  logic [3:0]  dw_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_stage_n #(.LANES(2)) d2 (
    .clk(clk), .rst(rst), .stallW(stall), .flushW(flush),
    .validM(valid[1:0]), .RegWriteM(regw[1:0]), .jumpM(jump[1:0]),
    .MemtoRegM(sel[3:0]), .ReadDataM(rdata[63:0]), .aluoutM(alu[63:0]),
    .PCPlus8M(pc8[63:0]), .writeregM(wreg[9:0]),
    .RegWriteW(d2_rw), .ResultW(d2_res), .WriteRegW(d2_wr),
    .retiredW(d2_ret), .retire_count(d2_cnt)
  );

  writeback_stage_n #(.LANES(4)) d4 (
    .clk(clk), .rst(rst), .stallW(stall), .flushW(flush),
    .validM(valid), .RegWriteM(regw), .jumpM(jump),
    .MemtoRegM(sel), .ReadDataM(rdata), .aluoutM(alu),
    .PCPlus8M(pc8), .writeregM(wreg),
    .RegWriteW(d4_rw), .ResultW(d4_res), .WriteRegW(d4_wr),
    .retiredW(d4_ret), .retire_count(d4_cnt)
  );

  writeback_stage_n #(.LANES(2), .CNT_W(4)) dw (
    .clk(clk), .rst(rst), .stallW(stall), .flushW(flush),
    .validM(valid[1:0]), .RegWriteM(regw[1:0]), .jumpM(jump[1:0]),
    .MemtoRegM(sel[3:0]), .ReadDataM(rdata[63:0]), .aluoutM(alu[63:0]),
    .PCPlus8M(pc8[63:0]), .writeregM(wreg[9:0]),
    .RegWriteW(dw_rw), .ResultW(dw_res), .WriteRegW(dw_wr),
    .retiredW(dw_ret), .retire_count(dw_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid = '0; regw = '0; jump = '0; sel = '0;
    rdata = '0; alu = '0; pc8 = '0; wreg = '0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic r, input logic j,
                          input logic [1:0] s, input logic [31:0] rd_v,
                          input logic [31:0] alu_v, input logic [31:0] pc_v,
                          input logic [4:0] w);
    valid[i] = v;
    regw[i]  = r;
    jump[i]  = j;
    sel[i*2 +: 2]    = s;
    rdata[i*32 +: 32] = rd_v;
    alu[i*32 +: 32]   = alu_v;
    pc8[i*32 +: 32]   = pc_v;
    wreg[i*5 +: 5]    = w;
  endtask

  initial begin
    // Reset with random inputs and stall/flush toggling.
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      valid = 4'($urandom); regw = 4'($urandom); jump = 4'($urandom); sel = 8'($urandom);
      rdata = {$urandom, $urandom, $urandom, $urandom};
      alu   = {$urandom, $urandom, $urandom, $urandom};
      pc8   = {$urandom, $urandom, $urandom, $urandom};
      wreg  = 20'($urandom);
      stall = c[0]; flush = c[1];
      tick();
    end
    check("rst_regwrite", d2_rw, 0);
    check("rst_result", d2_res, 0);
    check("rst_writereg", d2_wr, 0);
    check("rst_retired", d2_ret, 0);
    check("rst_count", d2_cnt, 0);
    check("rst_d4_retired", d4_ret, 0);

    // Mux/link bundle presented while still in reset: must not be captured.
    stall = 1'b0; flush = 1'b0;
    clear_inputs();
    set_lane(0, 1, 1, 0, 2'b01, 32'hDEADBEEF, 32'h1111_1111, 32'h2222_2222, 5'd8);
    set_lane(1, 1, 1, 1, 2'b10, 32'h3333_3333, 32'h4444_4444, 32'h0040_0010, 5'd3);
    tick();
    check("rst_overrides_bundle", d2_rw, 0);

    // E1: release, capture.
    rst = 1'b1;
    tick();
    check("mux_regwrite", d2_rw, 2'b11);
    check("mux_result", d2_res, {32'h0040_0010, 32'hDEADBEEF});
    check("mux_writereg", d2_wr, {5'd31, 5'd8});
    check("mux_retired", d2_ret, 2);
    check("mux_count", d2_cnt, 0);

    // E2: conflict, lanes 0/2/3 write r5.
    clear_inputs();
    set_lane(0, 1, 1, 0, 2'b00, 32'h0, 32'd1,    32'h0, 5'd5);
    set_lane(1, 1, 1, 0, 2'b00, 32'h0, 32'h77,   32'h0, 5'd7);
    set_lane(2, 1, 1, 0, 2'b00, 32'h0, 32'd2,    32'h0, 5'd5);
    set_lane(3, 1, 1, 0, 2'b00, 32'h0, 32'd3,    32'h0, 5'd5);
    tick();
    check("conf_d4_regwrite", d4_rw, 4'b1010);
    check("conf_d4_result", d4_res, {32'd3, 32'd2, 32'h77, 32'd1});
    check("conf_d4_writereg", d4_wr, {5'd5, 5'd5, 5'd7, 5'd5});
    check("conf_d4_retired", d4_ret, 4);
    check("conf_d2_regwrite", d2_rw, 2'b11);
    check("conf_d2_count", d2_cnt, 2);

    // E3: write to $0 suppressed; invalid lane with RegWrite does not write.
    clear_inputs();
    set_lane(0, 1, 1, 0, 2'b00, 32'h0, 32'h55, 32'h0, 5'd0);
    set_lane(1, 0, 1, 0, 2'b00, 32'h0, 32'h66, 32'h0, 5'd9);
    tick();
    check("zero_regwrite", d2_rw, 2'b00);
    check("zero_retired", d2_ret, 1);
    check("zero_count", d2_cnt, 4);
    check("zero_d4_count", d4_cnt, 6);

    // E4: two-lane bundle; lane1 uses sel=11 which acts as ALU.
    clear_inputs();
    set_lane(0, 1, 1, 0, 2'b00, 32'hFFFF_0000, 32'hA, 32'h0, 5'd10);
    set_lane(1, 1, 1, 0, 2'b11, 32'hFFFF_0001, 32'hB, 32'h0, 5'd11);
    tick();
    check("cap_result", d2_res, {32'hB, 32'hA});
    check("cap_count", d2_cnt, 5);

    // E5..E7: stall with changing inputs, everything holds.
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 1, 1, 1, 2'b01, 32'h9000 + c, 32'h8000 + c, 32'h7000, 5'd12);
      set_lane(1, 0, 0, 0, 2'b10, 32'h9100 + c, 32'h8100 + c, 32'h7100, 5'd13);
      tick();
    end
    check("stall_regwrite", d2_rw, 2'b11);
    check("stall_result", d2_res, {32'hB, 32'hA});
    check("stall_writereg", d2_wr, {5'd11, 5'd10});
    check("stall_retired", d2_ret, 2);
    check("stall_count", d2_cnt, 5);

    // E8: flush together with stall -> bubbles, departing bundle counted.
    flush = 1'b1;
    tick();
    check("flush_regwrite", d2_rw, 2'b00);
    check("flush_retired", d2_ret, 0);
    check("flush_count", d2_cnt, 7);

    // E9: bubble advances, counter unchanged.
    flush = 1'b0; stall = 1'b0;
    clear_inputs();
    tick();
    check("post_flush_count", d2_cnt, 7);

    // Counter wrap on the 4-bit instance.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_lane(0, 1, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd1);
    set_lane(1, 1, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd2);
    for (int c = 0; c < 7; c++) tick();
    clear_inputs();
    tick();
    check("wrap_preload", dw_cnt, 14);
    valid = 4'b0011;
    tick();
    valid = 4'b0001;
    tick();
    check("wrap_zero", dw_cnt, 0);
    valid = 4'b0000;
    tick();
    check("wrap_one", dw_cnt, 1);
    check("wide_count", d2_cnt, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
